// File: rtl/msg_proto_pkg.sv
// Protocol constants shared by the receive and transmit sides of the
// received-message buffer: the mandatory message prefix, the shortest legal
// message and the unloader state encodings.
package msg_proto_pkg;

  // Every message must start with this word.
  localparam logic [15:0] MSG_PREFIX  = 16'h55AA;

  // Shortest legal message length, in 16-bit words.
  localparam logic [7:0]  MIN_MSG_LEN = 8'd2;

  // Unloader states. These values appear on state_mon.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LEN_WAIT = 3'd1,
    ST_DATA     = 3'd2,
    ST_LAST     = 3'd3,
    ST_GAP      = 3'd4
  } unloader_state_e;

endpackage

// File: rtl/msg_unloader.sv
// Read side of the received-message buffer.
// It pops one message length from the length FIFO and then pops exactly that
// many 16-bit words from the data FIFO. The words are streamed downstream with
// start/end strobes. The leading 55AA prefix is checked, and completed messages
// are counted.
//
// Handshake: both FIFOs return data the cycle after a read request. Downstream
// TX_READY=1 in cycle N promises acceptance of a word presented in cycle N+1.
// A read is therefore only issued while TX_READY=1, and the word leaves on
// P_DATA_OUT/P_ENA_OUT exactly one cycle after its DATA_RDREQ. A message whose
// prefix is wrong is still drained, but it is drained silently and TX_READY is
// ignored for it.
module msg_unloader
  import msg_proto_pkg::*;
#(
  parameter logic [15:0] PREFIX = MSG_PREFIX,
  parameter int unsigned IFG    = 2
) (
  input  logic        RST,
  input  logic        RX_CLK,
  input  logic [7:0]  LEN_Q,
  input  logic        LEN_EMPTY,
  output logic        LEN_RDREQ,
  input  logic [15:0] DATA_Q,
  input  logic        DATA_EMPTY,
  output logic        DATA_RDREQ,
  input  logic        TX_READY,
  output logic [15:0] P_DATA_OUT,
  output logic        P_ENA_OUT,
  output logic        MSG_START,
  output logic        MSG_END,
  output logic        PREFIX_ERR,
  output logic        LEN_ERR,
  output logic [7:0]  MSG_CNT,
  output logic        BUSY,
  output logic [2:0]  state_mon
);

  unloader_state_e state, state_d;

  logic [7:0] remaining;
  logic       first;
  logic       discard;
  logic [7:0] gap_cnt;
  logic       rd_vld;
  logic [7:0] msg_cnt;

  logic       len_rdreq;
  logic       len_err;
  logic       data_rdreq;
  logic       pfx_bad;
  logic       discard_next;

  // Read-side datapath terms: the prefix check on the returning first word and
  // the data read request.
  always_comb begin
    pfx_bad      = rd_vld && first && (DATA_Q != PREFIX);
    discard_next = discard || pfx_bad;
    data_rdreq   = (state == ST_DATA) && !DATA_EMPTY &&
                   (TX_READY || discard) && (remaining != 8'd0);
  end

  // Next-state logic and the strobes that belong to single states.
  always_comb begin
    state_d   = state;
    len_rdreq = 1'b0;
    len_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!LEN_EMPTY) begin
          len_rdreq = 1'b1;
          state_d   = ST_LEN_WAIT;
        end
      end
      ST_LEN_WAIT: begin
        if (LEN_Q < MIN_MSG_LEN) begin
          len_err = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (data_rdreq && (remaining == 8'd1)) state_d = ST_LAST;
      end
      ST_LAST: begin
        state_d = (IFG == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt <= 8'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, the message counters and the one-cycle read-valid pipeline.
  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      remaining <= 8'd0;
      first     <= 1'b0;
      discard   <= 1'b0;
      gap_cnt   <= 8'd0;
      rd_vld    <= 1'b0;
      msg_cnt   <= 8'd0;
    end else begin
      state  <= state_d;
      rd_vld <= data_rdreq;
      if (rd_vld) first <= 1'b0;
      case (state)
        ST_LEN_WAIT: begin
          remaining <= LEN_Q;
          first     <= 1'b1;
          discard   <= 1'b0;
        end
        ST_DATA: begin
          if (data_rdreq) remaining <= remaining - 8'd1;
          if (pfx_bad)    discard   <= 1'b1;
        end
        ST_LAST: begin
          if (!discard_next) msg_cnt <= msg_cnt + 8'd1;
          gap_cnt <= 8'(IFG);
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Output mapping. The length pop is held off while reset is asserted, so
  // every output is quiet during reset.
  always_comb begin
    LEN_RDREQ  = len_rdreq && RST;
    DATA_RDREQ = data_rdreq;
    P_DATA_OUT = DATA_Q;
    P_ENA_OUT  = rd_vld && !discard_next;
    MSG_START  = rd_vld && !discard_next && first;
    MSG_END    = rd_vld && !discard_next && (state == ST_LAST);
    PREFIX_ERR = pfx_bad;
    LEN_ERR    = len_err;
    MSG_CNT    = msg_cnt;
    BUSY       = (state != ST_IDLE);
    state_mon  = state;
  end

endmodule

// File: tb/tb_msg_unloader.sv
// Bench for msg_unloader. Behavioural FIFO models feed the DUT. Messages are
// described as whole word lists. The expected output stream and the message,
// error and read totals come from those lists.
module tb_msg_unloader;
  import msg_proto_pkg::*;

  localparam int IFG = 2;

  logic        RST, RX_CLK;
  logic [7:0]  LEN_Q;
  logic        LEN_EMPTY, LEN_RDREQ;
  logic [15:0] DATA_Q;
  logic        DATA_EMPTY, DATA_RDREQ, TX_READY;
  logic [15:0] P_DATA_OUT;
  logic        P_ENA_OUT, MSG_START, MSG_END, PREFIX_ERR, LEN_ERR;
  logic [7:0]  MSG_CNT;
  logic        BUSY;
  logic [2:0]  state_mon;

  msg_unloader #(.PREFIX(MSG_PREFIX), .IFG(IFG)) dut (
    .RST(RST), .RX_CLK(RX_CLK),
    .LEN_Q(LEN_Q), .LEN_EMPTY(LEN_EMPTY), .LEN_RDREQ(LEN_RDREQ),
    .DATA_Q(DATA_Q), .DATA_EMPTY(DATA_EMPTY), .DATA_RDREQ(DATA_RDREQ),
    .TX_READY(TX_READY),
    .P_DATA_OUT(P_DATA_OUT), .P_ENA_OUT(P_ENA_OUT),
    .MSG_START(MSG_START), .MSG_END(MSG_END),
    .PREFIX_ERR(PREFIX_ERR), .LEN_ERR(LEN_ERR),
    .MSG_CNT(MSG_CNT), .BUSY(BUSY), .state_mon(state_mon)
  );

  // ---------------- clock / reset ----------------
  initial begin
    RX_CLK = 1'b0;
    forever #5 RX_CLK = ~RX_CLK;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- FIFO models ----------------
  logic [7:0]  len_stage[$];
  logic [7:0]  len_fifo[$];
  logic [15:0] word_stage[$];
  logic [15:0] data_fifo[$];
  int feed_mode = 1;  // 0: hold data back, 1: one word per cycle, 2: random
  int tx_mode   = 0;  // 0: always ready, 1: toggle, 2: random

  always @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      len_stage.delete(); len_fifo.delete();
      word_stage.delete(); data_fifo.delete();
      LEN_Q <= 8'd0; DATA_Q <= 16'd0;
      LEN_EMPTY <= 1'b1; DATA_EMPTY <= 1'b1;
    end else begin
      if (LEN_RDREQ && len_fifo.size() > 0) LEN_Q <= len_fifo.pop_front();
      if (DATA_RDREQ && data_fifo.size() > 0) DATA_Q <= data_fifo.pop_front();
      while (len_stage.size() > 0) len_fifo.push_back(len_stage.pop_front());
      if (word_stage.size() > 0 &&
          (feed_mode == 1 || (feed_mode == 2 && $urandom_range(0, 3) != 0)))
        data_fifo.push_back(word_stage.pop_front());
      LEN_EMPTY  <= (len_fifo.size() == 0);
      DATA_EMPTY <= (data_fifo.size() == 0);
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    TX_READY = 1'b0;
    forever begin
      @(negedge RX_CLK);
      case (tx_mode)
        0:       TX_READY = 1'b1;
        1:       TX_READY = ~TX_READY;
        default: TX_READY = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [17:0] exp_q[$];     // {start, end, word}
  logic [15:0] msg_w[$];     // words of the message being built
  int exp_cnt = 0, exp_pfx = 0, exp_lerr = 0, exp_rd = 0;

  task automatic push_custom(input int len);
    bit good;
    len_stage.push_back(8'(len));
    if (len < int'(MIN_MSG_LEN)) begin
      exp_lerr++;
      msg_w.delete();
      return;
    end
    good = (msg_w[0] == MSG_PREFIX);
    exp_rd += len;
    for (int i = 0; i < len; i++) begin
      word_stage.push_back(msg_w[i]);
      if (good) exp_q.push_back({(i == 0), (i == len - 1), msg_w[i]});
    end
    if (good) exp_cnt = (exp_cnt + 1) % 256;
    else      exp_pfx++;
    msg_w.delete();
  endtask

  task automatic push_msg(input int len, input bit good);
    logic [15:0] w;
    msg_w.delete();
    for (int i = 0; i < len; i++) begin
      w = 16'($urandom);
      if (i == 0) begin
        if (good) w = MSG_PREFIX;
        else if (w == MSG_PREFIX) w = w ^ 16'h0001;
      end
      msg_w.push_back(w);
    end
    push_custom(len);
  endtask

  // ---------------- monitor ----------------
  logic rdreq_prev, tx_prev;
  int cyc = 0, end_cyc = 0, start_cyc = 0, last_span = 0;
  int out_seen = 0, pfx_seen = 0, lerr_seen = 0, rd_seen = 0;
  bit end_pending = 0;

  always @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      rdreq_prev <= 1'b0;
      tx_prev    <= 1'b0;
    end else begin
      rdreq_prev <= DATA_RDREQ;
      tx_prev    <= TX_READY;
    end
  end

  always @(negedge RX_CLK) begin
    logic [17:0] e;
    if (RST) begin
      cyc++;
      if (DATA_RDREQ) rd_seen++;
      if (PREFIX_ERR) pfx_seen++;
      if (LEN_ERR)    lerr_seen++;
      check("rd_while_empty", {31'd0, DATA_RDREQ & DATA_EMPTY}, 0);
      check("len_rd_while_busy", {31'd0, LEN_RDREQ & BUSY}, 0);
      if (P_ENA_OUT) begin
        out_seen++;
        check("ena_after_rdreq", {31'd0, rdreq_prev}, 1);
        check("ena_after_ready", {31'd0, tx_prev}, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_word", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("word", {14'd0, MSG_START, MSG_END, P_DATA_OUT}, {14'd0, e});
        end
        if (MSG_START) start_cyc = cyc;
        if (MSG_END) begin
          last_span   = cyc - start_cyc;
          end_cyc     = cyc;
          end_pending = !LEN_EMPTY;
        end
      end else begin
        check("strobe_without_ena", {30'd0, MSG_START, MSG_END}, 0);
      end
      if (LEN_RDREQ && end_pending) begin
        check("ifg_gap", cyc - end_cyc, IFG + 1);
        end_pending = 0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((len_stage.size() + len_fifo.size() + word_stage.size() +
            data_fifo.size() != 0 || BUSY || exp_q.size() != 0) && n < budget) begin
      @(negedge RX_CLK);
      n++;
    end
    @(negedge RX_CLK);
    check({tag, "_timeout"}, (n < budget), 1);
    check({tag, "_msg_cnt"}, MSG_CNT, exp_cnt);
    check({tag, "_prefix_err"}, pfx_seen, exp_pfx);
    check({tag, "_len_err"}, lerr_seen, exp_lerr);
    check({tag, "_reads"}, rd_seen, exp_rd);
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ena"},   {31'd0, P_ENA_OUT}, 0);
    check({tag, "_start"}, {30'd0, MSG_START, MSG_END}, 0);
    check({tag, "_errs"},  {30'd0, PREFIX_ERR, LEN_ERR}, 0);
    check({tag, "_rdreq"}, {30'd0, LEN_RDREQ, DATA_RDREQ}, 0);
    check({tag, "_cnt"},   MSG_CNT, 0);
    check({tag, "_busy"},  {31'd0, BUSY}, 0);
    check({tag, "_state"}, state_mon, 0);
    check({tag, "_data"},  P_DATA_OUT, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rd_before, base, n, len, r;
    RST = 1'b1;
    #2 RST = 1'b0;
    repeat (3) @(negedge RX_CLK);
    check_quiet("reset");
    RST = 1'b1;

    // Back-to-back 3-word messages, downstream always ready.
    tx_mode = 0; feed_mode = 1;
    msg_w = '{16'h55AA, 16'h0140, 16'h1234};
    push_custom(3);
    push_msg(3, 1'b1);
    wait_done("basic", 200);
    check("basic_span", last_span, 2);

    // Same message with toggling TX_READY.
    tx_mode = 1;
    msg_w = '{16'h55AA, 16'h0140, 16'h1234};
    push_custom(3);
    wait_done("toggle", 200);

    // Length arrives ahead of its data: stall in DATA without reads.
    tx_mode = 0; feed_mode = 0;
    rd_before = rd_seen;
    push_msg(4, 1'b1);
    repeat (8) @(negedge RX_CLK);
    check("stall_state", state_mon, 2);
    check("stall_no_read", rd_seen, rd_before);
    feed_mode = 1;
    wait_done("stall", 200);

    // Bad prefix drained silently, followed by a good 2-word message.
    tx_mode = 2;
    msg_w = '{16'h1111, 16'h2222, 16'h3333};
    push_custom(3);
    msg_w = '{16'h55AA, 16'hFF00};
    push_custom(2);
    wait_done("prefix", 300);

    // Lengths below the minimum.
    push_custom(1);
    push_custom(0);
    wait_done("len_err", 100);

    // Maximum length message.
    feed_mode = 2;
    push_msg(255, 1'b1);
    wait_done("len255", 3000);

    // Randomized traffic; enough good messages to wrap MSG_CNT.
    for (int b = 0; b < 36; b++) begin
      for (int m = 0; m < 10; m++) begin
        r = $urandom_range(0, 99);
        if (r < 5)       len = $urandom_range(0, 1);
        else if (r < 12) len = $urandom_range(20, 40);
        else             len = $urandom_range(2, 8);
        push_msg(len, ($urandom_range(0, 9) != 0));
      end
      wait_done("random", 5000);
    end

    // Asynchronous reset in the middle of a 5-word message.
    tx_mode = 0; feed_mode = 1;
    base = out_seen;
    push_msg(5, 1'b1);
    n = 0;
    while (out_seen < base + 2 && n < 100) begin
      @(posedge RX_CLK);
      #1;
      n++;
    end
    check("midrst_reach", (n < 100), 1);
    RST = 1'b0;
    #1;
    check_quiet("midrst");
    exp_q.delete();
    exp_cnt = 0; exp_pfx = 0; exp_lerr = 0; exp_rd = 0;
    pfx_seen = 0; lerr_seen = 0; rd_seen = 0; end_pending = 0;
    repeat (2) @(negedge RX_CLK);
    check_quiet("midrst_hold");
    RST = 1'b1;
    repeat (4) @(negedge RX_CLK);
    check("post_rst_idle", state_mon, 0);
    push_msg(4, 1'b1);
    wait_done("post_rst", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
